// File: rtl/tb_signature_monitor_pkg.sv
// rtl/tb_signature_monitor_pkg.sv - shared types, constants and MISR step for the signature monitor
package tb_signature_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [15:0] DEFAULT_POLY = 16'h1021;
   localparam int          MAX_W        = 64;
   localparam int          IDX_W        = 6;

   // Operates on a MAX_W container; callers pass their real width so the
   // feedback tap and the result mask follow it.
   function automatic logic [MAX_W-1:0] misr_step(
      input logic [MAX_W-1:0] sig,
      input logic [MAX_W-1:0] data,
      input logic [MAX_W-1:0] poly,
      input int               width
   );
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] fb;
      mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
      fb   = sig[IDX_W'(width - 1)] ? poly : '0;
      return ((sig << 1) ^ fb ^ data) & mask;
   endfunction

endpackage

// File: rtl/tb_signature_monitor_misr_reg.sv
// rtl/tb_signature_monitor_misr_reg.sv - multiple-input signature register with seed load
module misr_reg
   import tb_signature_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input  logic             CLK,
   input  logic             RST_bar,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0] sig_nx;

   always_comb begin
      sig_nx = WIDTH'(misr_step(MAX_W'(sig), MAX_W'(data), MAX_W'(POLY), WIDTH));
   end

   // load outranks enable so a restart never folds in the sample on its edge
   always_ff @(posedge CLK) begin
      if (!RST_bar) begin
         sig <= SEED;
      end else if (load) begin
         sig <= SEED;
      end else if (enable) begin
         sig <= sig_nx;
      end
   end

endmodule

// File: rtl/tb_signature_monitor.sv
// rtl/tb_signature_monitor.sv - windowed response compactor with signature match flag
module tb_signature_monitor
   import tb_signature_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter int               CNT_W = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
   parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST_bar,
   input  logic             START,
   input  logic [CNT_W-1:0] LENGTH,
   input  logic             SAMPLE_EN,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic [WIDTH-1:0] EXPECTED,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SIGNATURE,
   output logic [CNT_W-1:0] TAKEN,
   output logic             MATCH
);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] len;
   logic             absorb;
   logic             last;

   assign absorb = (state == CAPTURE) && SAMPLE_EN && !START;
   assign last   = absorb && ((TAKEN + CNT_W'(1)) == len);

   always_ff @(posedge CLK) begin
      if (!RST_bar) begin
         state <= IDLE;
         len   <= '0;
         TAKEN <= '0;
      end else begin
         state <= state_nx;
         if (START) begin
            len   <= LENGTH;
            TAKEN <= '0;
         end else if (absorb) begin
            TAKEN <= TAKEN + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, tb_signature_pkg::DONE: begin
            if (START) state_nx = (LENGTH != '0) ? CAPTURE : tb_signature_pkg::DONE;
         end
         CAPTURE: begin
            if (START)     state_nx = (LENGTH != '0) ? CAPTURE : tb_signature_pkg::DONE;
            else if (last) state_nx = tb_signature_pkg::DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      BUSY  = (state == CAPTURE);
      DONE  = (state == tb_signature_pkg::DONE);
      MATCH = DONE && (SIGNATURE == EXPECTED);
   end

   misr_reg #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .CLK     (CLK),
      .RST_bar (RST_bar),
      .load    (START),
      .enable  (absorb),
      .data    (DATA_IN),
      .sig     (SIGNATURE)
   );

endmodule

// File: tb/tb_tb_signature_monitor.sv
// tb/tb_tb_signature_monitor.sv - randomized and directed bench for tb_signature_monitor
module tb_tb_signature_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  length;
   logic        sample_en;
   logic [15:0] data_in;
   logic [15:0] expected;

   logic        busy  [2];
   logic        done  [2];
   logic [15:0] sig   [2];
   logic [7:0]  taken [2];
   logic        match [2];

   int nchecks = 0;
   int nerr    = 0;

   // Reference state: window progress is shared, signature is per seed.
   logic [15:0] seeds [2];
   logic [15:0] m_sig [2];
   int          m_taken;
   int          m_len;
   bit          m_busy;
   bit          m_done;

   always #5 clk = ~clk;

   tb_signature_monitor #(.WIDTH(16), .CNT_W(8), .POLY(16'h1021), .SEED(16'h0000)) u_dut0 (
      .CLK(clk), .RST_bar(rst_n), .START(start), .LENGTH(length), .SAMPLE_EN(sample_en),
      .DATA_IN(data_in), .EXPECTED(expected), .BUSY(busy[0]), .DONE(done[0]),
      .SIGNATURE(sig[0]), .TAKEN(taken[0]), .MATCH(match[0])
   );

   tb_signature_monitor #(.WIDTH(16), .CNT_W(8), .POLY(16'h1021), .SEED(16'h8000)) u_dut1 (
      .CLK(clk), .RST_bar(rst_n), .START(start), .LENGTH(length), .SAMPLE_EN(sample_en),
      .DATA_IN(data_in), .EXPECTED(expected), .BUSY(busy[1]), .DONE(done[1]),
      .SIGNATURE(sig[1]), .TAKEN(taken[1]), .MATCH(match[1])
   );

   // Shift-and-fold as polynomial arithmetic: double mod 2^16, reduce by the tap on overflow.
   function automatic logic [15:0] ref_fold(input logic [15:0] s, input logic [15:0] d);
      int unsigned v;
      v = 32'(s) * 2;
      if (v >= 32'h1_0000) v = (v - 32'h1_0000) ^ 32'h1021;
      return 16'(v) ^ d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s.busy%0d", tag, i), 32'(busy[i]), 32'(m_busy));
         chk($sformatf("%s.done%0d", tag, i), 32'(done[i]), 32'(m_done));
         chk($sformatf("%s.sig%0d", tag, i), 32'(sig[i]), 32'(m_sig[i]));
         chk($sformatf("%s.taken%0d", tag, i), 32'(taken[i]), 32'(m_taken));
         chk($sformatf("%s.match%0d", tag, i), 32'(match[i]), 32'(m_done && (m_sig[i] == expected)));
      end
   endtask

   task automatic step(input string tag, input logic r, input logic s, input logic [7:0] l,
                       input logic e, input logic [15:0] d);
      rst_n = r; start = s; length = l; sample_en = e; data_in = d;
      @(posedge clk);
      @(negedge clk);
      if (!r) begin
         m_busy = 0; m_done = 0; m_taken = 0; m_len = 0;
         for (int i = 0; i < 2; i++) m_sig[i] = seeds[i];
      end else if (s) begin
         m_len = int'(l); m_taken = 0;
         m_busy = (l != 0); m_done = (l == 0);
         for (int i = 0; i < 2; i++) m_sig[i] = seeds[i];
      end else if (m_busy && e) begin
         for (int i = 0; i < 2; i++) m_sig[i] = ref_fold(m_sig[i], d);
         m_taken++;
         if (m_taken == m_len) begin
            m_busy = 0; m_done = 1;
         end
      end
      rst_n = 1'b1; start = 1'b0; sample_en = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic [5:0] gap_pat;
      seeds[0] = 16'h0000;
      seeds[1] = 16'h8000;
      rst_n = 1'b0; start = 1'b0; length = '0; sample_en = 1'b0; data_in = '0; expected = '0;
      @(negedge clk);

      step("reset", 1'b0, 1'b0, 8'd0, 1'b0, 16'h0);
      step("reset2", 1'b0, 1'b1, 8'd3, 1'b1, 16'hffff);

      step("rmc_start", 1'b1, 1'b1, 8'd5, 1'b0, 16'h0);
      step("rmc_s1", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));
      step("rmc_s2", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));
      step("rmc_rst", 1'b0, 1'b0, 8'd0, 1'b1, 16'($urandom));

      step("one_start", 1'b1, 1'b1, 8'd1, 1'b0, 16'h0);
      step("one_s1", 1'b1, 1'b0, 8'd0, 1'b1, 16'h0001);
      chk("one_const", 32'(sig[0]), 32'h0001);
      step("two_start", 1'b1, 1'b1, 8'd2, 1'b0, 16'h0);
      step("two_s1", 1'b1, 1'b0, 8'd0, 1'b1, 16'h0001);
      step("two_s2", 1'b1, 1'b0, 8'd0, 1'b1, 16'h0000);
      chk("two_const", 32'(sig[0]), 32'h0002);
      chk("two_taken", 32'(taken[0]), 32'd2);

      step("tap_start", 1'b1, 1'b1, 8'd1, 1'b0, 16'h0);
      step("tap_s1", 1'b1, 1'b0, 8'd0, 1'b1, 16'h0000);
      chk("tap_const", 32'(sig[1]), 32'h1021);
      expected = 16'h1021; #1;
      check_all("tap_match");
      chk("tap_match_const", 32'(match[1]), 32'd1);
      expected = 16'h1020; #1;
      check_all("tap_nomatch");
      chk("tap_nomatch_const", 32'(match[1]), 32'd0);

      step("gap_start", 1'b1, 1'b1, 8'd3, 1'b0, 16'h0);
      gap_pat = 6'b101001;
      for (int k = 0; k < 6; k++) begin
         step($sformatf("gap_e%0d", k), 1'b1, 1'b0, 8'd0, gap_pat[k], 16'($urandom));
         chk($sformatf("gap_busy%0d", k), 32'(busy[0]), (k < 5) ? 32'd1 : 32'd0);
      end
      chk("gap_done", 32'(done[0]), 32'd1);
      chk("gap_taken", 32'(taken[0]), 32'd3);

      step("len0_start", 1'b1, 1'b1, 8'd0, 1'b1, 16'h1234);
      chk("len0_seed", 32'(sig[1]), 32'h8000);
      for (int k = 0; k < 3; k++)
         step("len0_hold", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));

      step("sic_start", 1'b1, 1'b1, 8'd4, 1'b0, 16'h0);
      step("sic_s1", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));
      step("sic_s2", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));
      step("sic_restart", 1'b1, 1'b1, 8'd1, 1'b1, 16'hbeef);
      chk("sic_taken", 32'(taken[0]), 32'd0);
      step("sic_s3", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));
      chk("sic_done", 32'(done[0]), 32'd1);

      step("max_start", 1'b1, 1'b1, 8'd255, 1'b0, 16'h0);
      for (int k = 0; k < 255; k++)
         step("max_s", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));
      chk("max_taken", 32'(taken[0]), 32'd255);
      step("max_hold", 1'b1, 1'b0, 8'd0, 1'b1, 16'($urandom));

      for (int k = 0; k < 400; k++) begin
         step("rnd", $urandom_range(0, 39) != 0, $urandom_range(0, 9) == 0,
              8'($urandom_range(0, 6)), $urandom_range(0, 2) != 0, 16'($urandom));
         if (m_done) begin
            expected = ($urandom_range(0, 1) != 0) ? m_sig[0] : m_sig[1];
            #1;
            check_all("rnd_match");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
